// File: rtl/link_test_sequencer_if.sv
// rtl/link_test_sequencer_if.sv - control and status bundle of the link test sequencer
interface link_test_sequencer_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   start;
  logic                   abort;
  logic [COUNT_WIDTH-1:0] num_symbols;
  logic                   sym_valid;
  logic                   chan_valid;
  logic                   gen_en;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [COUNT_WIDTH-1:0] sym_count;
  logic [COUNT_WIDTH-1:0] out_count;

  modport master (
    output start, abort, num_symbols, sym_valid, chan_valid,
    input  gen_en, busy, done, err, sym_count, out_count
  );

  modport slave (
    input  start, abort, num_symbols, sym_valid, chan_valid,
    output gen_en, busy, done, err, sym_count, out_count
  );
endinterface

// File: rtl/link_test_sequencer.sv
// rtl/link_test_sequencer.sv - burst run controller for the PRBS/encoder/channel chain
// Optional RUN watchdog enabled by defining SEQ_TIMEOUT_EN.
module link_test_sequencer #(
  parameter int COUNT_WIDTH    = 16,
  parameter int DRAIN_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                  clk,
  input logic                  rst,
  link_test_sequencer_if.slave bus
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state;
  logic [COUNT_WIDTH-1:0] target;
  logic [COUNT_WIDTH-1:0] sym_count;
  logic [COUNT_WIDTH-1:0] out_count;
  logic [COUNT_WIDTH-1:0] sym_next;
  logic [COUNT_WIDTH-1:0] out_next;
  logic [DW-1:0]          drain_cnt;
  logic                   gen_en;
  logic                   busy;
  logic                   done;

`ifdef SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_cnt;
  logic          err;
  assign bus.err = err;
`else
  // No watchdog in this build: err is a constant zero.
  assign bus.err = (TIMEOUT_CYCLES < 0);
`endif

  assign sym_next = (sym_count == CNT_MAX) ? sym_count : sym_count + 1'b1;
  assign out_next = (out_count == CNT_MAX) ? out_count : out_count + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      target    <= '0;
      sym_count <= '0;
      out_count <= '0;
      drain_cnt <= '0;
      gen_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wd_cnt    <= '0;
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sym_count <= '0;
            out_count <= '0;
`ifdef SEQ_TIMEOUT_EN
            wd_cnt    <= '0;
            err       <= 1'b0;
`endif
            if (bus.num_symbols != '0) begin
              target <= bus.num_symbols;
              state  <= RUN;
              gen_en <= 1'b1;
              busy   <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          // Abort wins over target-reached and watchdog; counters freeze as they are.
          if (bus.abort) begin
            state  <= IDLE;
            gen_en <= 1'b0;
            busy   <= 1'b0;
          end else begin
            if (bus.chan_valid) out_count <= out_next;
            if (bus.sym_valid) begin
              sym_count <= sym_next;
`ifdef SEQ_TIMEOUT_EN
              wd_cnt    <= '0;
`endif
              if (sym_next == target) begin
                state     <= DRAIN;
                gen_en    <= 1'b0;
                drain_cnt <= DW'(DRAIN_CYCLES);
              end
            end
`ifdef SEQ_TIMEOUT_EN
            else if (wd_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
              state  <= IDLE;
              gen_en <= 1'b0;
              busy   <= 1'b0;
              err    <= 1'b1;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
`endif
          end
        end
        DRAIN: begin
          if (bus.abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (bus.chan_valid) out_count <= out_next;
            if (drain_cnt == DW'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt - 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gen_en    = gen_en;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.sym_count = sym_count;
  assign bus.out_count = out_count;
endmodule

// File: tb/tb_link_test_sequencer.sv
// tb/tb_link_test_sequencer.sv - self-checking bench for link_test_sequencer
module tb_link_test_sequencer;
  localparam int CW    = 16;
  localparam int D     = 8;
  localparam int TO    = 64;
  localparam int L_MAX = 100;
  localparam int BIG   = 1000000;
`ifdef SEQ_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  link_test_sequencer_if #(.COUNT_WIDTH(CW)) bus ();

  link_test_sequencer #(.COUNT_WIDTH(CW), .DRAIN_CYCLES(D), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  string scn;

  bit st_s[L_MAX];
  bit ab_s[L_MAX];
  bit sv_s[L_MAX];
  bit cv_s[L_MAX];
  int n_s[L_MAX];

  // Run timeline: accepted start, end of generation, end of busy, how the run ended.
  int m_s, m_how, m_run_end, m_stop, m_abort;
  int first_done, last_gen, last_busy, fin_sym, fin_out, fin_err;

  task automatic chk(input string name, input int c, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s/%s cycle %0d: got %0d expected %0d", scn, name, c, act, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < L_MAX; i++) begin
      st_s[i] = 0; ab_s[i] = 0; sv_s[i] = 0; cv_s[i] = 0; n_s[i] = 3;
    end
  endtask

  function automatic int hits(input bit is_sym, input int lo, input int hi);
    int k = 0;
    for (int u = lo; u <= hi && u < L_MAX; u++)
      if (u >= 0) k += is_sym ? int'(sv_s[u]) : int'(cv_s[u]);
    return k;
  endfunction

  // how: 0 ongoing, 1 target reached, 2 aborted, 3 timeout, 4 zero-length
  task automatic build_model(input int L);
    int cnt, gap;
    m_s = BIG; m_how = 0; m_run_end = BIG; m_stop = BIG; m_abort = -1;
    for (int c = 0; c < L; c++) if (st_s[c]) begin m_s = c; break; end
    if (m_s == BIG) return;
    if (n_s[m_s] == 0) begin
      m_how = 4; m_run_end = m_s + 1; m_stop = m_s + 1;
      return;
    end
    cnt = 0; gap = 0;
    for (int u = m_s + 1; u < L; u++) begin
      if (ab_s[u]) begin m_abort = u; m_run_end = u + 1; m_stop = u + 1; m_how = 2; break; end
      if (sv_s[u]) begin
        cnt++; gap = 0;
        if (cnt == n_s[m_s]) begin m_run_end = u + 1; m_how = 1; break; end
      end else begin
        gap++;
        if (TO_ON && gap == TO) begin m_run_end = u + 1; m_stop = u + 1; m_how = 3; break; end
      end
    end
    if (m_how == 1) begin
      m_stop = m_run_end + D;
      for (int u = m_run_end; u < m_run_end + D && u < L; u++)
        if (ab_s[u]) begin m_abort = u; m_stop = u + 1; m_how = 2; break; end
    end
  endtask

  task automatic run_scn(input string nm, input int L);
    int sym_hi, chan_hi, e_sym, e_out;
    scn = nm;
    build_model(L);
    first_done = -1; last_gen = -1; last_busy = -1;
    @(negedge clk);
    rst = 1; bus.start = 1; bus.abort = 1; bus.num_symbols = 7; bus.sym_valid = 1; bus.chan_valid = 1;
    @(negedge clk);
    chk("rst_gen_en", -1, bus.gen_en, 0);
    chk("rst_busy", -1, bus.busy, 0);
    chk("rst_done", -1, bus.done, 0);
    chk("rst_err", -1, bus.err, 0);
    chk("rst_sym_count", -1, bus.sym_count, 0);
    chk("rst_out_count", -1, bus.out_count, 0);
    sym_hi  = (m_abort >= 0 && m_abort < m_run_end) ? m_abort - 1 : m_run_end - 1;
    chan_hi = (m_abort >= 0) ? m_abort - 1 : m_stop - 1;
    for (int c = 0; c < L; c++) begin
      @(negedge clk);
      e_sym = hits(1'b1, m_s + 1, (c - 1 < sym_hi) ? c - 1 : sym_hi);
      e_out = hits(1'b0, m_s + 1, (c - 1 < chan_hi) ? c - 1 : chan_hi);
      chk("gen_en", c, bus.gen_en, (m_how != 4 && c > m_s && c < m_run_end) ? 1 : 0);
      chk("busy", c, bus.busy, (m_how != 4 && c > m_s && c < m_stop) ? 1 : 0);
      chk("done", c, bus.done,
          ((m_how == 1 && c == m_stop) || (m_how == 4 && c == m_s + 1)) ? 1 : 0);
      chk("err", c, bus.err, (m_how == 3 && c >= m_run_end) ? 1 : 0);
      chk("sym_count", c, bus.sym_count, (e_sym > 65535) ? 65535 : e_sym);
      chk("out_count", c, bus.out_count, (e_out > 65535) ? 65535 : e_out);
      if (bus.done && first_done < 0) first_done = c;
      if (bus.gen_en) last_gen = c;
      if (bus.busy) last_busy = c;
      fin_sym = int'(bus.sym_count); fin_out = int'(bus.out_count); fin_err = int'(bus.err);
      rst = 0;
      bus.start = st_s[c]; bus.abort = ab_s[c]; bus.num_symbols = CW'(n_s[c]);
      bus.sym_valid = sv_s[c]; bus.chan_valid = cv_s[c];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; bus.start = 0; bus.abort = 0; bus.num_symbols = 0; bus.sym_valid = 0; bus.chan_valid = 0;

    // Burst of 10, a symbol every 2nd cycle, stray symbol in DRAIN, starts ignored in RUN/DRAIN/DONE
    clear_stim();
    n_s[0] = 10; st_s[0] = 1; st_s[5] = 1; st_s[24] = 1; st_s[29] = 1;
    for (int c = 2; c <= 20; c += 2) sv_s[c] = 1;
    sv_s[22] = 1;
    for (int c = 0; c < 34; c += 3) cv_s[c] = 1;
    run_scn("burst10", 34);
    chk("burst10_done_cycle", 0, first_done, 29);
    chk("burst10_last_gen", 0, last_gen, 20);
    chk("burst10_sym_count", 0, fin_sym, 10);
    chk("burst10_out_count", 0, fin_out, 9);

    // Zero-length burst
    clear_stim();
    n_s[2] = 0; st_s[2] = 1; sv_s[3] = 1; sv_s[4] = 1; cv_s[3] = 1; cv_s[4] = 1;
    run_scn("zero", 8);
    chk("zero_done_cycle", 0, first_done, 3);
    chk("zero_gen_seen", 0, last_gen, -1);
    chk("zero_busy_seen", 0, last_busy, -1);
    chk("zero_sym_count", 0, fin_sym, 0);

    // Abort after 5 of 20 symbols
    clear_stim();
    n_s[0] = 20; st_s[0] = 1; ab_s[6] = 1;
    for (int c = 1; c <= 5; c++) sv_s[c] = 1;
    for (int c = 0; c < 12; c++) cv_s[c] = 1;
    run_scn("abort5", 12);
    chk("abort5_sym_count", 0, fin_sym, 5);
    chk("abort5_out_count", 0, fin_out, 5);
    chk("abort5_last_gen", 0, last_gen, 6);
    chk("abort5_done", 0, first_done, -1);

    // Abort coincident with the final symbol
    clear_stim();
    n_s[0] = 20; st_s[0] = 1; ab_s[20] = 1;
    for (int c = 1; c <= 20; c++) sv_s[c] = 1;
    run_scn("abort_last", 26);
    chk("abort_last_sym_count", 0, fin_sym, 19);
    chk("abort_last_last_busy", 0, last_busy, 20);
    chk("abort_last_done", 0, first_done, -1);

    // Abort during DRAIN
    clear_stim();
    n_s[0] = 3; st_s[0] = 1; ab_s[6] = 1;
    for (int c = 1; c <= 3; c++) sv_s[c] = 1;
    for (int c = 0; c < 14; c++) cv_s[c] = 1;
    run_scn("abort_drain", 14);
    chk("abort_drain_out_count", 0, fin_out, 5);
    chk("abort_drain_last_busy", 0, last_busy, 6);
    chk("abort_drain_done", 0, first_done, -1);

    // No symbols at all after start
    clear_stim();
    n_s[0] = 5; st_s[0] = 1;
    run_scn("starve", 72);
`ifdef SEQ_TIMEOUT_EN
    chk("starve_last_gen", 0, last_gen, 64);
    chk("starve_err", 0, fin_err, 1);
    chk("starve_done", 0, first_done, -1);
    @(negedge clk);
    bus.start = 1; bus.num_symbols = 0;
    @(negedge clk);
    bus.start = 0;
    chk("restart_err_clear", 0, bus.err, 0);
    chk("restart_done", 0, bus.done, 1);
`else
    chk("starve_last_gen", 0, last_gen, 71);
    chk("starve_err", 0, fin_err, 0);
    chk("starve_done", 0, first_done, -1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
